// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg
// Shared definitions for the 4x4 keypad scanner:
//   - scan_state_t : controller states (scan, debounce, pressed)
//   - ROW_IDLE     : row_s value with no key down (pull-ups, active-low)
//   - COL_SEL      : one-cold, active-low column drive, indexed by column
//   - row_encode() : lowest-index low row bit wins
package keypad_scanner_pkg;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2
   } scan_state_t;

   localparam logic [3:0] ROW_IDLE = 4'b1111;

   // COL_SEL[0] = 4'b1110 ... COL_SEL[3] = 4'b0111
   localparam logic [3:0][3:0] COL_SEL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

   // Scanning downwards means the lowest low bit is the last one written.
   function automatic logic [1:0] row_encode(input logic [3:0] row);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!row[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scanner_tick_gen.sv
// scan_tick_gen
// Free-running divider: counts 0..SCAN_DIV-1 and wraps. tick is high for the
// single cycle in which the count equals SCAN_DIV-1. Also usable as the
// digit-multiplex strobe of a display driver.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset (count cleared)
//   tick  out one-cycle pulse every SCAN_DIV clocks
module scan_tick_gen #(
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(SCAN_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column per tick, debounces the
// row pattern and emits one key event per physical press.
// Ports:
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   row_in    in  [3:0] row sense, active-low, asynchronous to clk
//   col_out   out [3:0] one-cold active-low column drive
//   key_code  out [3:0] {row_idx, col_idx} of the last accepted key
//   key_valid out one-cycle strobe when a press is accepted
//   key_held  out high from press acceptance until release acceptance
// Interface: key_valid is a strobe with no back-pressure; the consumer must
// take key_code in the cycle key_valid is high. key_code stays stable until
// the next event, so it may also be read at any time while key_held is high.
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 100000,
   parameter int unsigned DEBOUNCE_CNT = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int unsigned CNTW = $clog2(DEBOUNCE_CNT + 1);

   logic              tick;
   logic [3:0]        sync1, row_s;
   scan_state_t       state, state_n;
   logic [1:0]        col_idx, col_n;
   logic [3:0]        pat, pat_n;
   logic [1:0]        row_idx, ridx_n;
   logic [CNTW-1:0]   cnt, cnt_n, cnt_inc;
   logic [3:0]        code_n;
   logic              valid_n, held_n, accept;

   scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // Column is only ever changed on a tick, so the row seen on a tick has
   // settled for a whole dwell under the column currently driven.
   assign col_out = COL_SEL[col_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1     <= ROW_IDLE;
         row_s     <= ROW_IDLE;
         state     <= ST_SCAN;
         col_idx   <= 2'd0;
         pat       <= ROW_IDLE;
         row_idx   <= 2'd0;
         cnt       <= '0;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         sync1     <= row_in;
         row_s     <= sync1;
         state     <= state_n;
         col_idx   <= col_n;
         pat       <= pat_n;
         row_idx   <= ridx_n;
         cnt       <= cnt_n;
         key_code  <= code_n;
         key_valid <= valid_n;
         key_held  <= held_n;
      end
   end

   // One counter serves both the press count (DEBOUNCE) and the release
   // count (PRESSED); it is cleared on every state change between them.
   always_comb begin
      state_n = state;
      col_n   = col_idx;
      pat_n   = pat;
      ridx_n  = row_idx;
      cnt_n   = cnt;
      code_n  = key_code;
      valid_n = 1'b0;
      held_n  = key_held;
      accept  = 1'b0;
      cnt_inc = cnt + CNTW'(1);

      if (tick) begin
         case (state)
            ST_SCAN: begin
               if (row_s == ROW_IDLE) begin
                  col_n = col_idx + 2'd1;
               end else begin
                  pat_n  = row_s;
                  ridx_n = row_encode(row_s);
                  cnt_n  = CNTW'(1);
                  if (DEBOUNCE_CNT == 1) accept  = 1'b1;
                  else                   state_n = ST_DEBOUNCE;
               end
            end
            ST_DEBOUNCE: begin
               if (row_s == pat) begin
                  if (cnt_inc == CNTW'(DEBOUNCE_CNT)) accept = 1'b1;
                  else                                cnt_n  = cnt_inc;
               end else begin
                  cnt_n   = '0;
                  col_n   = col_idx + 2'd1;
                  state_n = ST_SCAN;
               end
            end
            ST_PRESSED: begin
               // Column stays frozen: other columns are invisible and a
               // pattern change within this column is not a new event.
               if (row_s == ROW_IDLE) begin
                  if (cnt_inc == CNTW'(DEBOUNCE_CNT)) begin
                     held_n  = 1'b0;
                     cnt_n   = '0;
                     col_n   = col_idx + 2'd1;
                     state_n = ST_SCAN;
                  end else begin
                     cnt_n = cnt_inc;
                  end
               end else begin
                  cnt_n = '0;
               end
            end
            default: begin
               cnt_n   = '0;
               state_n = ST_SCAN;
            end
         endcase
      end

      if (accept) begin
         valid_n = 1'b1;
         held_n  = 1'b1;
         code_n  = {ridx_n, col_idx};
         cnt_n   = '0;
         state_n = ST_PRESSED;
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Keypad matrix model drives row_in from col_out and a set of pressed keys.
// A procedural reference model follows the scanner rules per clock; outputs
// are compared every negedge, key events go through an expected queue, and
// directed scenarios check the documented event codes.
module tb_keypad_scanner;

   localparam int unsigned SCAN_DIV     = 4;
   localparam int unsigned DEBOUNCE_CNT = 3;

   logic        clk;
   logic        rst_n;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;

   logic [15:0] key_map;   // bit r*4+c set = key at row r, column c pressed

   int total = 0;
   int bad   = 0;
   int ev_cnt = 0;
   logic [3:0] last_code = 4'd0;

   logic [3:0] exp_q[$];

   // reference model state
   int         m_cyc, m_mode, m_col, m_run, m_ridx;
   logic [3:0] m_pat, m_code;
   logic       m_held, m_valid;
   logic [3:0] sync_q[$];

   keypad_scanner #(
      .SCAN_DIV     (SCAN_DIV),
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .row_in    (row_in),
      .col_out   (col_out),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- keypad matrix ----------------
   always_comb begin
      row_in = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (key_map[r*4 + c] && !col_out[c]) row_in[r] = 1'b0;
         end
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int lowest_low(input logic [3:0] r);
      for (int i = 0; i < 4; i++) if (!r[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_cyc = 0; m_mode = 0; m_col = 0; m_run = 0; m_ridx = 0;
      m_pat = 4'hF; m_code = 4'd0; m_held = 1'b0; m_valid = 1'b0;
      sync_q.delete();
      sync_q.push_back(4'hF);
      sync_q.push_back(4'hF);
      exp_q.delete();
   endtask

   task automatic model_accept();
      m_valid = 1'b1;
      m_code  = 4'(m_ridx * 4 + m_col);
      exp_q.push_back(m_code);
      m_held  = 1'b1;
      m_run   = 0;
      m_mode  = 2;
   endtask

   // One clock edge: rin is the row value present at that edge.
   task automatic model_step(input logic [3:0] rin);
      logic [3:0] rs;
      bit         tick;
      sync_q.push_back(rin);
      rs    = sync_q.pop_front();
      tick  = ((m_cyc % SCAN_DIV) == SCAN_DIV - 1);
      m_cyc = m_cyc + 1;
      m_valid = 1'b0;
      if (tick) begin
         if (m_mode == 0) begin
            if (rs == 4'hF) m_col = (m_col + 1) % 4;
            else begin
               m_pat = rs; m_ridx = lowest_low(rs); m_run = 1;
               if (m_run >= DEBOUNCE_CNT) model_accept();
               else m_mode = 1;
            end
         end else if (m_mode == 1) begin
            if (rs == m_pat) begin
               m_run = m_run + 1;
               if (m_run >= DEBOUNCE_CNT) model_accept();
            end else begin
               m_run = 0; m_col = (m_col + 1) % 4; m_mode = 0;
            end
         end else begin
            if (rs == 4'hF) begin
               m_run = m_run + 1;
               if (m_run >= DEBOUNCE_CNT) begin
                  m_held = 1'b0; m_run = 0; m_col = (m_col + 1) % 4; m_mode = 0;
               end
            end else begin
               m_run = 0;
            end
         end
      end
   endtask

   // Inputs only change at posedge+2, so values at negedge equal those at
   // the next posedge.
   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         if (!rst_n) model_reset();
         check("col_out",   32'(col_out),   32'(4'hF ^ (4'd1 << m_col)));
         check("key_valid", 32'(key_valid), 32'(m_valid));
         check("key_held",  32'(key_held),  32'(m_held));
         check("key_code",  32'(key_code),  32'(m_code));
         if (key_valid === 1'b1) begin
            ev_cnt++;
            last_code = key_code;
            if (exp_q.size() > 0) check("sb_code", 32'(key_code), 32'(exp_q.pop_front()));
            else check("sb_unexpected_valid", 32'(key_valid), 32'd0);
         end
         if (rst_n) model_step(row_in);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_held(input logic val, input int budget, input string tag);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (key_held === val) break;
      end
      check(tag, 32'(key_held), 32'(val));
   endtask

   task automatic press_wait(input logic [15:0] map, input logic [3:0] code, input string tag);
      int e0;
      e0 = ev_cnt;
      key_map = map;
      wait_held(1'b1, 300, {tag, "_held"});
      cyc(1);
      check({tag, "_events"}, 32'(ev_cnt - e0), 32'd1);
      check({tag, "_code"}, 32'(last_code), 32'(code));
   endtask

   task automatic release_wait(input string tag);
      key_map = 16'd0;
      wait_held(1'b0, 300, {tag, "_release"});
      cyc(1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int e0;
      logic [15:0] map;
      rst_n   = 1'b0;
      key_map = 16'd0;
      cyc(3);
      check("rst_col_out",   32'(col_out),   32'(4'b1110));
      check("rst_key_valid", 32'(key_valid), 32'd0);
      check("rst_key_held",  32'(key_held),  32'd0);
      check("rst_key_code",  32'(key_code),  32'd0);
      rst_n = 1'b1;

      // 1: idle scanning
      e0 = ev_cnt;
      cyc(40);
      check("s1_idle_events", 32'(ev_cnt - e0), 32'd0);

      // 2: row1,col2 press and release
      press_wait(16'd1 << 6, 4'b0110, "s2");
      check("s2_col_frozen", 32'(col_out), 32'(4'b1011));
      cyc(20);
      check("s2_col_still_frozen", 32'(col_out), 32'(4'b1011));
      key_map = 16'd0;
      wait_held(1'b0, 300, "s2_release");
      check("s2_col_after", 32'(col_out), 32'(4'b0111));
      cyc(1);

      // 3: bouncing row3,col0 then a stable press
      e0 = ev_cnt;
      repeat (12) begin
         key_map = 16'd1 << 12;
         cyc(4);
         key_map = 16'd0;
         cyc(4);
      end
      check("s3_bounce_events", 32'(ev_cnt - e0), 32'd0);
      press_wait(16'd1 << 12, 4'b1100, "s3");
      release_wait("s3");

      // 4: second key in another column while the first is held
      press_wait(16'd1 << 1, 4'b0001, "s4a");
      e0 = ev_cnt;
      key_map = key_map | (16'd1 << 11);
      cyc(60);
      check("s4_no_second", 32'(ev_cnt - e0), 32'd0);
      key_map = 16'd1 << 11;
      wait_held(1'b0, 300, "s4_first_release");
      wait_held(1'b1, 300, "s4_second_held");
      cyc(1);
      check("s4_second_events", 32'(ev_cnt - e0), 32'd1);
      check("s4_second_code", 32'(last_code), 32'(4'b1011));
      release_wait("s4");

      // 5: two keys in column 0, lowest row wins
      press_wait((16'd1 << 0) | (16'd1 << 8), 4'b0000, "s5");
      release_wait("s5");

      // 6: reset while held, key re-detected afterwards
      press_wait(16'd1 << 6, 4'b0110, "s6");
      rst_n = 1'b0;
      #1;
      check("s6_async_held", 32'(key_held), 32'd0);
      check("s6_async_col",  32'(col_out),  32'(4'b1110));
      check("s6_async_code", 32'(key_code), 32'd0);
      cyc(2);
      rst_n = 1'b1;
      e0 = ev_cnt;
      wait_held(1'b1, 300, "s6_redetect_held");
      cyc(1);
      check("s6_redetect_events", 32'(ev_cnt - e0), 32'd1);
      check("s6_redetect_code", 32'(last_code), 32'(4'b0110));
      release_wait("s6");

      // random presses, checked by the reference model each cycle
      repeat (30) begin
         map = 16'd1 << $urandom_range(0, 15);
         if ($urandom_range(0, 2) == 0) map = map | (16'd1 << $urandom_range(0, 15));
         key_map = map;
         cyc(int'($urandom_range(3, 70)));
         key_map = 16'd0;
         cyc(int'($urandom_range(3, 50)));
      end
      cyc(80);
      check("sb_drain", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
